serial_subtractor: RTL and testbench
====================================

# serial_subtractor

Bit-serial N-bit subtractor computing D = A − B one bit per clock, LSB first, using a single full-subtractor cell and a registered borrow. It is the subtracting counterpart to the team's adder cells. It sits beside the ripple adders in the ALU datapath wherever area matters more than latency. Operands are captured on a start pulse; the result, borrow, overflow and zero flags are presented together with a one-cycle done pulse.

## Interface
- N, default 8: operand/result width in bits; legal N ≥ 2.
- clk  input  1  rising-edge clock; the only clock.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request; sampled on rising clk edges; accepted only in IDLE or DONE.
- A  input  N  minuend; captured on the accepting edge only.
- B  input  N  subtrahend; captured on the accepting edge only.
- D  output  N  difference A − B mod 2^N; registered; holds until the next completion.
- B_out  output  1  final borrow; 1 iff A < B unsigned.
- V  output  1  signed (two's-complement) overflow of A − B.
- Z  output  1  1 iff D == 0.
- busy  output  1  high while an operation is in progress (SHIFT state).
- done  output  1  single-cycle pulse when D/B_out/V/Z update.

## Operation
- States:
  - IDLE: busy=0, done=0.
  - SHIFT: busy=1, done=0.
  - DONE: busy=0, done=1.
- Internal registers:
  - a_sr, b_sr: N-bit operand shift registers.
  - r_sr: N-bit result shift register.
  - bor: 1-bit running borrow.
  - cnt: bit counter, width ⌈log2 N⌉+1.
  - a_msb, b_msb: operand sign bits, kept for V.
- Accepting edge (start=1 in IDLE or DONE):
  - a_sr←A, b_sr←B, bor←0, cnt←0.
  - a_msb←A[N−1], b_msb←B[N−1].
  - Next state SHIFT.
- Each SHIFT edge (a=a_sr[0], b=b_sr[0]):
  - d = a ^ b ^ bor.
  - bor ← (~a & b) | (~(a ^ b) & bor).
  - r_sr ← {d, r_sr[N−1:1]}; a_sr, b_sr shift right by one; cnt ← cnt+1.
- Final SHIFT edge (cnt == N−1):
  - D ← {d, r_sr[N−1:1]}.
  - B_out ← next-bor value.
  - V ← (a_msb ≠ b_msb) & (d ≠ a_msb).
  - Z ← ({d, r_sr[N−1:1]} == 0).
  - Next state DONE.
- DONE: lasts exactly one cycle, then goes to IDLE. If start=1 in DONE, that edge is the accepting edge of a new operation and the next state is SHIFT.
- start in SHIFT is ignored. A and B are don't-care except on the accepting edge.
- No-start edges in IDLE leave all outputs unchanged.

## Timing
- Reset (asynchronous, immediate): state=IDLE; D=0, B_out=0, V=0, Z=0, busy=0, done=0; all internal registers 0.
- Accepting edge at edge k:
  - busy=1 after edge k through edge k+N.
  - D/B_out/V/Z update and done=1 after edge k+N.
  - done=0 again after edge k+N+1.
- Latency is N cycles from the accepting edge to valid result. Throughput is one operation per N+1 cycles, with start held or re-asserted during DONE.
- Outputs change only on the completion edge or on reset; never mid-operation.
- rst asserted mid-SHIFT: operation aborted, no done pulse, outputs cleared. The first accepted start after rst deasserts behaves normally.
- start coincident with rst deassertion: not accepted unless sampled high on a clk edge with rst low.

## Test plan
- Reset: assert rst asynchronously between clock edges → all outputs 0 immediately. Deassert, idle 5 cycles → outputs stay 0, done never pulses.
- Basic: N=8, A=100, B=37, start 1 cycle → busy for 8 cycles; done pulse on cycle 8; D=63, B_out=0, V=0, Z=0.
- Borrow and signed overflow:
  - A=0x05, B=0x09 → D=0xFC, B_out=1, V=0.
  - A=0x80, B=0x01 → D=0x7F, B_out=0, V=1.
- Zero and edge values:
  - A=0x5A, B=0x5A → D=0x00, Z=1, B_out=0.
  - A=0x00, B=0xFF → D=0x01, B_out=1, V=0.
- Handshake:
  - Hold start high continuously with A/B changing every cycle → results only for operands present on accepting edges; done every 9 cycles.
  - Pulse start mid-SHIFT → ignored, result unaffected.
- Abort: start A=0xF0, B=0x0F; assert rst after 4 SHIFT cycles → no done, outputs 0. Then A=0x30, B=0x10 → D=0x20, done after 8 cycles.

Source files
------------

// File: rtl/serial_subtractor.sv
// Bit-serial N-bit subtractor: D = A - B, one bit per clock, LSB first, using a single
// full-subtractor cell and a registered borrow. Flags and done pulse appear together.
module serial_subtractor #(
   parameter int unsigned N = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         start,
   input  logic [N-1:0] A,
   input  logic [N-1:0] B,
   output logic [N-1:0] D,
   output logic         B_out,
   output logic         V,
   output logic         Z,
   output logic         busy,
   output logic         done
);

   localparam int unsigned CW = $clog2(N) + 1;

   typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

   state_e         state_q, state_d;
   logic [N-1:0]   a_sr, b_sr, r_sr;
   logic           bor;
   logic [CW-1:0]  cnt;
   logic           a_msb, b_msb;

   logic           a_bit, b_bit, d_bit, bor_nxt;
   logic [N-1:0]   res_nxt;
   logic           accept, last;

   // Full-subtractor cell on the current LSBs
   always_comb begin
      a_bit   = a_sr[0];
      b_bit   = b_sr[0];
      d_bit   = a_bit ^ b_bit ^ bor;
      bor_nxt = (~a_bit & b_bit) | (~(a_bit ^ b_bit) & bor);
      res_nxt = {d_bit, r_sr[N-1:1]};
      accept  = start && (state_q != StShift);
      last    = (state_q == StShift) && (cnt == CW'(N - 1));
   end

   always_comb begin
      state_d = state_q;
      busy    = 1'b0;
      done    = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (start) state_d = StShift;
         end
         StShift: begin
            busy = 1'b1;
            if (last) state_d = StDone;
         end
         StDone: begin
            done    = 1'b1;
            state_d = start ? StShift : StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= StIdle;
         a_sr    <= '0;
         b_sr    <= '0;
         r_sr    <= '0;
         bor     <= 1'b0;
         cnt     <= '0;
         a_msb   <= 1'b0;
         b_msb   <= 1'b0;
         D       <= '0;
         B_out   <= 1'b0;
         V       <= 1'b0;
         Z       <= 1'b0;
      end else begin
         state_q <= state_d;
         if (accept) begin
            a_sr  <= A;
            b_sr  <= B;
            bor   <= 1'b0;
            cnt   <= '0;
            a_msb <= A[N-1];
            b_msb <= B[N-1];
         end else if (state_q == StShift) begin
            a_sr <= a_sr >> 1;
            b_sr <= b_sr >> 1;
            r_sr <= res_nxt;
            bor  <= bor_nxt;
            cnt  <= cnt + CW'(1);
            // Outputs only move on the completion edge
            if (last) begin
               D     <= res_nxt;
               B_out <= bor_nxt;
               V     <= (a_msb != b_msb) && (d_bit != a_msb);
               Z     <= (res_nxt == '0);
            end
         end
      end
   end

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed bench for serial_subtractor: expected results are queued when an operation is
// started and compared by a monitor whenever done pulses.
module tb_serial_subtractor;

   localparam int unsigned N = 8;

   logic         clk = 1'b0;
   logic         rst;
   logic         start;
   logic [N-1:0] A, B, D;
   logic         B_out, V, Z, busy, done;

   int errors = 0;
   int checks = 0;

   typedef struct packed {
      logic [N-1:0] d;
      logic         bo;
      logic         v;
      logic         z;
   } res_t;

   res_t exp_q[$];

   serial_subtractor #(.N(N)) dut (
      .clk   (clk),
      .rst   (rst),
      .start (start),
      .A     (A),
      .B     (B),
      .D     (D),
      .B_out (B_out),
      .V     (V),
      .Z     (Z),
      .busy  (busy),
      .done  (done)
   );

   always #5 clk = ~clk;

   function automatic res_t model(input logic [N-1:0] a, input logic [N-1:0] b);
      res_t r;
      r.d  = a - b;
      r.bo = (a < b);
      r.v  = (a[N-1] != b[N-1]) && (r.d[N-1] != a[N-1]);
      r.z  = (r.d == '0);
      return r;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Scoreboard side: every done pulse must match the oldest queued result
   always @(negedge clk) begin
      if (!rst && done) begin
         if (exp_q.size() == 0) begin
            chk("spurious_done", 32'(done), 32'd0);
         end else begin
            res_t e;
            e = exp_q.pop_front();
            chk("D", 32'(D), 32'(e.d));
            chk("B_out", 32'(B_out), 32'(e.bo));
            chk("V", 32'(V), 32'(e.v));
            chk("Z", 32'(Z), 32'(e.z));
            chk("busy_in_done", 32'(busy), 32'd0);
         end
      end
   end

   task automatic start_op(input logic [N-1:0] a, input logic [N-1:0] b, input bit push);
      @(negedge clk);
      A     = a;
      B     = b;
      start = 1'b1;
      if (push) exp_q.push_back(model(a, b));
      @(negedge clk);
      start = 1'b0;
      A     = $urandom;
      B     = $urandom;
   endtask

   task automatic drain(input string tag);
      int n = 0;
      while (exp_q.size() != 0 && n < 20) begin
         @(negedge clk);
         #1;
         n++;
      end
      chk(tag, 32'(exp_q.size()), 32'd0);
      @(negedge clk);
      chk({tag, "_done_low"}, 32'(done), 32'd0);
   endtask

   task automatic chk_cleared(input string tag);
      chk({tag, "_D"}, 32'(D), 32'd0);
      chk({tag, "_flags"}, {28'd0, B_out, V, Z, done}, 32'd0);
      chk({tag, "_busy"}, 32'(busy), 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end

   initial begin
      rst   = 1'b1;
      start = 1'b0;
      A     = '0;
      B     = '0;
      #1;
      chk_cleared("reset");
      repeat (2) @(negedge clk);
      rst = 1'b0;
      repeat (5) begin
         @(negedge clk);
         chk("idle_done", 32'(done), 32'd0);
         chk("idle_D", 32'(D), 32'd0);
      end

      // Basic: busy for N cycles, then done with the result
      @(negedge clk);
      A     = 8'd100;
      B     = 8'd37;
      start = 1'b1;
      exp_q.push_back(model(8'd100, 8'd37));
      for (int i = 0; i < N; i++) begin
         @(negedge clk);
         start = 1'b0;
         chk("basic_busy", 32'(busy), 32'd1);
         chk("basic_no_done", 32'(done), 32'd0);
         chk("basic_D_hold", 32'(D), 32'd0);
      end
      @(negedge clk);
      #1;
      chk("basic_done", 32'(done), 32'd1);
      chk("basic_D63", 32'(D), 32'd63);
      drain("basic_drain");

      // Asynchronous reset between edges clears outputs immediately
      #2 rst = 1'b1;
      #1;
      chk_cleared("async_rst");
      @(negedge clk);
      rst = 1'b0;

      start_op(8'h05, 8'h09, 1'b1);
      drain("borrow");
      start_op(8'h80, 8'h01, 1'b1);
      drain("overflow");
      start_op(8'h5A, 8'h5A, 1'b1);
      drain("zero");
      start_op(8'h00, 8'hFF, 1'b1);
      drain("edge_ff");
      start_op(8'hFF, 8'h00, 1'b1);
      drain("edge_ff0");
      start_op(8'h7F, 8'h80, 1'b1);
      drain("overflow_pos");

      // start held high: only every (N+1)-th edge is an accepting edge
      @(negedge clk);
      start = 1'b1;
      for (int i = 0; i < 3 * (N + 1); i++) begin
         A = $urandom;
         B = $urandom;
         if (i % (N + 1) == 0) exp_q.push_back(model(A, B));
         @(negedge clk);
      end
      start = 1'b0;
      drain("held_start");

      // start pulsed mid-SHIFT is ignored
      start_op(8'h05, 8'h09, 1'b1);
      repeat (3) @(negedge clk);
      A     = 8'hAA;
      B     = 8'h11;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      drain("mid_start");
      chk("mid_start_idle", 32'(busy), 32'd0);

      // Abort mid-operation; nothing queued for the aborted op
      start_op(8'hF0, 8'h0F, 1'b0);
      repeat (3) @(negedge clk);
      chk("abort_busy", 32'(busy), 32'd1);
      #2 rst = 1'b1;
      #1;
      chk_cleared("abort");
      repeat (3) begin
         @(negedge clk);
         chk("abort_no_done", 32'(done), 32'd0);
      end
      rst = 1'b0;
      repeat (N + 2) begin
         @(negedge clk);
         chk("post_abort_quiet", {30'd0, done, busy}, 32'd0);
      end
      start_op(8'h30, 8'h10, 1'b1);
      drain("after_abort");
      chk("after_abort_D", 32'(D), 32'h20);

      chk("queue_empty", 32'(exp_q.size()), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
